// File: rtl/toy_kernel_arbiter_if.sv
// toy_kernel_arbiter_if: requester and kernel stream bundle shared by the arbiter and its environment
interface toy_kernel_arbiter_if #(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_NUM_REQ = 2
);
  logic [C_NUM_REQ-1:0] req_in_avail, req_in_ready, req_out_ready, req_out_avail;
  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_in_data;
  logic [C_DATA_WIDTH-1:0] req_out_data, k_in_data, k_out_data;
  logic k_in_avail, k_in_ready, k_out_avail, k_out_ready;
  modport slave (
    input req_in_avail, req_in_data, req_out_ready, k_in_ready, k_out_avail, k_out_data,
    output req_in_ready, req_out_avail, req_out_data, k_in_avail, k_in_data, k_out_ready
  );
  modport master (
    output req_in_avail, req_in_data, req_out_ready, k_in_ready, k_out_avail, k_out_data,
    input req_in_ready, req_out_avail, req_out_data, k_in_avail, k_in_data, k_out_ready
  );
endinterface

// File: rtl/toy_kernel_arbiter.sv
// toy_kernel_arbiter: round-robin grant of one kernel to several requesters, one input beat then N output beats
module toy_kernel_arbiter #(
  parameter int C_DATA_WIDTH = 512,
  parameter int C_NUM_REQ = 2
) (
  input  logic clk,
  input  logic reset,
  toy_kernel_arbiter_if.slave bus,
  output logic busy,
  output logic [1:0] owner,
  output logic err,
  output logic [15:0] xact_cnt
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [1:0] rr_ptr, grant;
  logic [7:0] remaining, n;
  logic [C_NUM_REQ-1:0] sel;
  logic [C_DATA_WIDTH-1:0] slice;
  logic in_done, in_acc, out_acc, release_x, active, any_req;
  assign active = state == ACTIVE;
  assign any_req = |bus.req_in_avail;
  assign sel = C_NUM_REQ'(1) << owner;
  assign slice = C_DATA_WIDTH'(bus.req_in_data >> (int'(owner) * C_DATA_WIDTH));
  assign n = slice[7:0];
  assign bus.k_in_avail = active && !in_done && |(bus.req_in_avail & sel);
  assign bus.k_in_data = active ? slice : '0;
  assign bus.req_in_ready = (active && !in_done && bus.k_in_ready) ? sel : '0;
  assign bus.k_out_ready = active && |(bus.req_out_ready & sel);
  assign bus.req_out_avail = (active && bus.k_out_avail) ? sel : '0;
  assign bus.req_out_data = active ? bus.k_out_data : '0;
  assign in_acc = bus.k_in_avail && bus.k_in_ready;
  assign out_acc = bus.k_out_avail && bus.k_out_ready;
  assign release_x = active && in_done && remaining == 8'd0;
  assign busy = active;
  // scan from the highest offset down so the lowest offset from rr_ptr wins
  always_comb begin
    grant = rr_ptr;
    for (int i = C_NUM_REQ - 1; i >= 0; i--)
      if (|(bus.req_in_avail & (C_NUM_REQ'(1) << 2'((int'(rr_ptr) + i) % C_NUM_REQ))))
        grant = 2'((int'(rr_ptr) + i) % C_NUM_REQ);
  end
  always_comb state_nxt = release_x ? IDLE : (!active && any_req) ? ACTIVE : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner <= '0;
      rr_ptr <= '0;
      remaining <= '0;
      in_done <= 1'b0;
      err <= 1'b0;
      xact_cnt <= '0;
    end else begin
      if (!active && any_req) owner <= grant;
      if (in_acc) begin
        in_done <= 1'b1;
        remaining <= (out_acc && n != 8'd0) ? n - 8'd1 : n;
      end else if (in_done && out_acc && remaining != 8'd0) remaining <= remaining - 8'd1;
      // output beats with no transaction credit left to absorb them are protocol errors
      if (out_acc && (in_acc ? n == 8'd0 : (!in_done || remaining == 8'd0))) err <= 1'b1;
      if (release_x) begin
        in_done <= 1'b0;
        rr_ptr <= 2'((int'(owner) + 1) % C_NUM_REQ);
        xact_cnt <= xact_cnt + 16'd1;
      end
    end
endmodule

// File: tb/tb_toy_kernel_arbiter.sv
// tb_toy_kernel_arbiter: directed transactions against a simple kernel model with hand-computed expectations
module tb_toy_kernel_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err;
  logic [1:0] owner;
  logic [15:0] xact_cnt;
  int checks = 0;
  int errors = 0;
  int got, cyc;
  toy_kernel_arbiter_if #(.C_DATA_WIDTH(DW), .C_NUM_REQ(NR)) bus();
  toy_kernel_arbiter #(.C_DATA_WIDTH(DW), .C_NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .owner(owner), .err(err), .xact_cnt(xact_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] din(input int r, input logic [7:0] n);
    return 32'hC0DE0000 | (32'(r) << 8) | 32'(n);
  endfunction
  task automatic load(input int r, input logic [7:0] n);
    bus.req_in_data[r*DW +: DW] = din(r, n);
    bus.req_in_avail[r] = 1'b1;
  endtask
  task automatic wait_grant(input int r);
    int w = 0;
    while (!busy && w < 10) begin
      step;
      w++;
    end
    check("grant_seen", 64'(busy), 64'd1);
    check("owner", 64'(owner), 64'(r));
  endtask
  task automatic serve(input int r, input int n, input bit drop, input int stall_at, input int stall_len,
                       output int got_o, output int cyc_o);
    int sent = 0;
    int st = 0;
    bit stall;
    got_o = 0;
    cyc_o = 0;
    while (busy && cyc_o < 100) begin
      stall = sent >= stall_at && st < stall_len;
      bus.k_out_avail = sent < n;
      bus.k_out_data = 32'hA000 + 32'(sent);
      bus.req_out_ready = stall ? '0 : '1;
      #1;
      if (cyc_o == 0) begin
        check("k_in_avail", 64'(bus.k_in_avail), 64'd1);
        check("k_in_data", 64'(bus.k_in_data), 64'(din(r, 8'(n))));
        check("req_in_ready", 64'(bus.req_in_ready), 64'd1 << r);
      end
      if (cyc_o == 1) check("in_closed", {62'd0, bus.k_in_avail, |bus.req_in_ready}, 64'd0);
      if (stall) begin
        st++;
        check("stall_k_out_ready", 64'(bus.k_out_ready), 64'd0);
        check("stall_remaining", 64'(dut.remaining), 64'(n - sent));
      end
      if (bus.k_out_avail && bus.k_out_ready) begin
        if (bus.req_out_avail[r] && bus.req_out_data == bus.k_out_data) got_o++;
        sent++;
      end
      step;
      if (drop && cyc_o == 0) bus.req_in_avail[r] = 1'b0;
      cyc_o++;
    end
    bus.k_out_avail = 1'b0;
    bus.req_out_ready = '0;
    check("released", 64'(busy), 64'd0);
  endtask
  initial begin
    bus.req_in_avail = '0;
    bus.req_in_data = '0;
    bus.req_out_ready = '0;
    bus.k_in_ready = 1'b1;
    bus.k_out_avail = 1'b0;
    bus.k_out_data = '0;
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_status", {45'd0, owner, err, xact_cnt}, 64'd0);
    check("rst_handshake", {59'd0, bus.k_in_avail, bus.k_out_ready, bus.req_in_ready, bus.req_out_avail}, 64'd0);
    step;
    reset = 1'b0;
    step;
    load(0, 8'h03);
    wait_grant(0);
    serve(0, 3, 1'b1, 99, 0, got, cyc);
    check("t1_beats", 64'(got), 64'd3);
    check("t1_cycles", 64'(cyc), 64'd4);
    check("t1_xact", 64'(xact_cnt), 64'd1);
    check("t1_rr", 64'(dut.rr_ptr), 64'd1);
    check("t1_err", 64'(err), 64'd0);
    load(1, 8'h00);
    wait_grant(1);
    serve(1, 0, 1'b1, 99, 0, got, cyc);
    check("n0_beats", 64'(got), 64'd0);
    check("n0_cycles", 64'(cyc), 64'd2);
    check("n0_xact", 64'(xact_cnt), 64'd2);
    load(0, 8'h01);
    wait_grant(0);
    serve(0, 1, 1'b1, 99, 0, got, cyc);
    check("n1_beats", 64'(got), 64'd1);
    check("n1_cycles", 64'(cyc), 64'd2);
    check("n1_err", 64'(err), 64'd0);
    load(1, 8'h06);
    wait_grant(1);
    serve(1, 6, 1'b1, 2, 5, got, cyc);
    check("stall_beats", 64'(got), 64'd6);
    check("stall_cycles", 64'(cyc), 64'd12);
    check("stall_xact", 64'(xact_cnt), 64'd4);
    load(0, 8'h01);
    wait_grant(0);
    bus.req_in_avail[0] = 1'b0;
    bus.k_out_avail = 1'b1;
    bus.req_out_ready = '1;
    #1;
    check("drop_k_in_avail", 64'(bus.k_in_avail), 64'd0);
    step;
    check("drop_hold", 64'(busy), 64'd1);
    check("drop_owner", 64'(owner), 64'd0);
    check("early_out_err", 64'(err), 64'd1);
    bus.k_out_avail = 1'b0;
    bus.req_out_ready = '0;
    bus.req_in_avail[0] = 1'b1;
    serve(0, 1, 1'b1, 99, 0, got, cyc);
    check("drop_beats", 64'(got), 64'd1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    load(0, 8'h02);
    load(1, 8'h02);
    for (int i = 0; i < 4; i++) begin
      wait_grant(i % 2);
      serve(i % 2, 2, 1'b0, 99, 0, got, cyc);
      check("rr_beats", 64'(got), 64'd2);
    end
    bus.req_in_avail = '0;
    check("rr_xact", 64'(xact_cnt), 64'd4);
    step;
    load(0, 8'h05);
    wait_grant(0);
    bus.k_out_avail = 1'b1;
    bus.k_out_data = 32'hBEEF;
    bus.req_out_ready = '1;
    step;
    bus.req_in_avail = '0;
    check("pre_rst_remaining", 64'(dut.remaining), 64'd4);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_status", {45'd0, owner, err, xact_cnt}, 64'd0);
    check("mid_rst_handshake", {59'd0, bus.k_in_avail, bus.k_out_ready, bus.req_in_ready, bus.req_out_avail}, 64'd0);
    check("mid_rst_remaining", 64'(dut.remaining), 64'd0);
    bus.k_out_avail = 1'b0;
    bus.req_out_ready = '0;
    step;
    reset = 1'b0;
    load(1, 8'h01);
    wait_grant(1);
    check("post_rst_xact", 64'(xact_cnt), 64'd0);
    check("post_rst_err", 64'(err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
